// File: rtl/keypad_scanner_if.sv
// Keypad scanner port bundle: matrix strobe/return lines plus the valid/ready key output.
// The scanner takes the master side; the keypad/consumer takes the slave side.
interface keypad_scanner_if #(
    parameter int unsigned ROWS   = 4,
    parameter int unsigned COLS   = 4,
    parameter int unsigned CODE_W = 4
);
    logic [ROWS-1:0]   row;
    logic [COLS-1:0]   col;
    logic [CODE_W-1:0] key_code;
    logic              key_valid;
    logic              key_ready;
    logic              key_held;
    logic              overflow;

    modport master (
        input  row, key_ready,
        output col, key_code, key_valid, key_held, overflow
    );

    modport slave (
        output row, key_ready,
        input  col, key_code, key_valid, key_held, overflow
    );
endinterface

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: strobes columns one-hot, synchronises and debounces row returns,
// and hands exactly one key code per physical press to a valid/ready consumer.
module keypad_scanner #(
    parameter int unsigned ROWS            = 4,
    parameter int unsigned COLS            = 4,
    parameter int unsigned SCAN_DIV        = 4800,
    parameter int unsigned DEBOUNCE_CYCLES = 480000,
    parameter bit          HEX_MAP         = 1'b1
) (
    input logic              clk,
    input logic              reset,
    keypad_scanner_if.master kp
);
    localparam int unsigned CODE_W = HEX_MAP ? 4 : $clog2(ROWS * COLS);
    localparam int unsigned ColW   = $clog2(COLS);
    localparam int unsigned RowW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned ScanW  = $clog2(SCAN_DIV);
    localparam int unsigned DebW   = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [ColW-1:0]  ColLast  = ColW'(COLS - 1);
    localparam logic [ScanW-1:0] ScanLast = ScanW'(SCAN_DIV - 1);
    localparam logic [DebW-1:0]  DebLast  = DebW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {StScan, StDebounce, StHeld} state_e;

    state_e            state_q, state_d;
    logic [ROWS-1:0]   row_meta_q, row_sync_q;
    logic [ColW-1:0]   col_idx_q, col_idx_d, col_next;
    logic [RowW-1:0]   row_idx_q, row_idx_d;
    logic [ScanW-1:0]  scan_cnt_q, scan_cnt_d;
    logic [DebW-1:0]   deb_cnt_q, deb_cnt_d;
    logic [CODE_W-1:0] key_code_q, key_code_d, code_new;
    logic              key_valid_q, key_valid_d;
    logic              overflow_q, overflow_d;
    logic              capture;

    function automatic logic [RowW-1:0] lowest_set(input logic [ROWS-1:0] v);
        lowest_set = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = RowW'(i);
        end
    endfunction

    if (HEX_MAP) begin : g_hex
        // Nibble i holds the legend of row i/4, column i%4.
        localparam logic [63:0] HexLut = 64'hDF0E_C987_B654_A321;
        logic [3:0] key_idx;
        assign key_idx  = 4'({row_idx_q, col_idx_q});
        assign code_new = CODE_W'(HexLut[{key_idx, 2'b00} +: 4]);
    end else begin : g_lin
        assign code_new = CODE_W'(32'(row_idx_q) * COLS + 32'(col_idx_q));
    end

    assign col_next = (col_idx_q == ColLast) ? '0 : col_idx_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        row_idx_d   = row_idx_q;
        scan_cnt_d  = scan_cnt_q;
        deb_cnt_d   = deb_cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = key_valid_q;
        overflow_d  = 1'b0;
        capture     = 1'b0;

        unique case (state_q)
            StScan: begin
                if (scan_cnt_q == ScanLast) begin
                    scan_cnt_d = '0;
                    if (|row_sync_q) begin
                        row_idx_d = lowest_set(row_sync_q);
                        deb_cnt_d = '0;
                        state_d   = StDebounce;
                    end else begin
                        col_idx_d = col_next;
                    end
                end else begin
                    scan_cnt_d = scan_cnt_q + 1'b1;
                end
            end
            StDebounce: begin
                if (!row_sync_q[row_idx_q]) begin
                    state_d   = StScan;
                    col_idx_d = col_next;
                end else if (deb_cnt_q == DebLast) begin
                    capture   = 1'b1;
                    deb_cnt_d = '0;
                    state_d   = StHeld;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            StHeld: begin
                // Any row activity, from this key or another, restarts the release count.
                if (|row_sync_q) begin
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DebLast) begin
                    deb_cnt_d = '0;
                    state_d   = StScan;
                    col_idx_d = col_next;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            default: state_d = StScan;
        endcase

        if (capture) begin
            if (!key_valid_q || kp.key_ready) begin
                key_code_d  = code_new;
                key_valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (key_valid_q && kp.key_ready) begin
            key_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_meta_q  <= '0;
            row_sync_q  <= '0;
            state_q     <= StScan;
            col_idx_q   <= '0;
            row_idx_q   <= '0;
            scan_cnt_q  <= '0;
            deb_cnt_q   <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            row_meta_q  <= kp.row;
            row_sync_q  <= row_meta_q;
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            row_idx_q   <= row_idx_d;
            scan_cnt_q  <= scan_cnt_d;
            deb_cnt_q   <= deb_cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    assign kp.col       = {{(COLS - 1){1'b0}}, 1'b1} << col_idx_q;
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_held  = (state_q == StHeld);
    assign kp.overflow  = overflow_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a 4x4 hex instance and a 3x5 linear instance driven by a
// physical keypad model, checked every cycle against a procedural reference model.
module tb_keypad_scanner;
    localparam int SD = 4;
    localparam int DB = 8;
    localparam logic [3:0] HEX_TAB [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                           4'h4, 4'h5, 4'h6, 4'hB,
                                           4'h7, 4'h8, 4'h9, 4'hC,
                                           4'hE, 4'h0, 4'hF, 4'hD};

    logic clk;
    logic reset;
    logic [15:0] keys [2];
    logic        rdy [2];

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    keypad_scanner_if #(.ROWS(4), .COLS(4), .CODE_W(4)) kp0 ();
    keypad_scanner_if #(.ROWS(3), .COLS(5), .CODE_W(4)) kp1 ();

    keypad_scanner #(.ROWS(4), .COLS(4), .SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB), .HEX_MAP(1'b1))
        u_dut0 (.clk(clk), .reset(reset), .kp(kp0.master));
    keypad_scanner #(.ROWS(3), .COLS(5), .SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB), .HEX_MAP(1'b0))
        u_dut1 (.clk(clk), .reset(reset), .kp(kp1.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical keypad: a pressed key shorts its column strobe onto its row line.
    always_comb begin
        kp0.row = '0;
        for (int r = 0; r < 4; r++) kp0.row[r] = |(keys[0][r*4 +: 4] & kp0.col);
    end
    always_comb begin
        kp1.row = '0;
        for (int r = 0; r < 3; r++) kp1.row[r] = |(keys[1][r*5 +: 5] & kp1.col);
    end
    assign kp0.key_ready = rdy[0];
    assign kp1.key_ready = rdy[1];

    logic [7:0] row_m [2], col_m [2];
    logic [3:0] code_m [2];
    logic       valid_m [2], held_m [2], ovf_m [2];
    assign row_m[0] = 8'(kp0.row);      assign row_m[1] = 8'(kp1.row);
    assign col_m[0] = 8'(kp0.col);      assign col_m[1] = 8'(kp1.col);
    assign code_m[0] = kp0.key_code;    assign code_m[1] = kp1.key_code;
    assign valid_m[0] = kp0.key_valid;  assign valid_m[1] = kp1.key_valid;
    assign held_m[0] = kp0.key_held;    assign held_m[1] = kp1.key_held;
    assign ovf_m[0] = kp0.overflow;     assign ovf_m[1] = kp1.overflow;

    // Reference model state: 0 scanning, 1 debouncing, 2 held.
    logic [7:0] m_meta [2] = '{8'h00, 8'h00};
    logic [7:0] m_sync [2] = '{8'h00, 8'h00};
    logic [7:0] e_col [2] = '{8'h01, 8'h01};
    logic [3:0] e_code [2] = '{4'h0, 4'h0};
    logic       e_valid [2] = '{1'b0, 1'b0};
    logic       e_held [2] = '{1'b0, 1'b0};
    logic       e_ovf [2] = '{1'b0, 1'b0};
    int         m_phase [2] = '{0, 0};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] code_of(input int g, input int r, input int c);
        if (g == 0) return HEX_TAB[r*4 + c];
        return 4'(r*5 + c);
    endfunction

    // One clock of the model: inputs are taken just before the edge, as the flops see them.
    task automatic m_edge(input int g, output logic [7:0] s, output bit rdy_s, output bit rst_s);
        @(negedge clk);
        #4;
        s     = m_sync[g];
        rdy_s = rdy[g];
        rst_s = reset;
        @(posedge clk);
        m_sync[g] = m_meta[g];
        m_meta[g] = row_m[g];
        if (rst_s) begin
            m_meta[g]  = 8'h00;
            m_sync[g]  = 8'h00;
            e_col[g]   = 8'h01;
            e_code[g]  = 4'h0;
            e_valid[g] = 1'b0;
            e_held[g]  = 1'b0;
            e_ovf[g]   = 1'b0;
            m_phase[g] = 0;
        end
    endtask

    task automatic m_commit(input int g, input bit rdy_s, input bit cap, input logic [3:0] code,
                            input bit held);
        e_ovf[g] = 1'b0;
        if (cap) begin
            if (!e_valid[g] || rdy_s) begin
                e_code[g]  = code;
                e_valid[g] = 1'b1;
            end else begin
                e_ovf[g] = 1'b1;
            end
        end else if (e_valid[g] && rdy_s) begin
            e_valid[g] = 1'b0;
        end
        e_held[g] = held;
    endtask

    task automatic run_model(input int g);
        logic [7:0] s;
        bit rdy_s, rst_s, hit;
        int c, r, cnt, ncol;
        ncol = (g == 0) ? 4 : 5;
        forever begin
            c = 0;
            rst_s = 1'b0;
            while (!rst_s) begin
                e_col[g] = 8'd1 << c;
                m_phase[g] = 0;
                for (int k = 0; k < SD; k++) begin
                    m_edge(g, s, rdy_s, rst_s);
                    if (rst_s) break;
                    m_commit(g, rdy_s, 1'b0, 4'h0, 1'b0);
                end
                if (rst_s) break;
                if (s == 8'h00) begin
                    c = (c + 1) % ncol;
                    continue;
                end
                r = 0;
                while (!s[r]) r++;
                m_phase[g] = 1;
                hit = 1'b0;
                for (int k = 1; k <= DB; k++) begin
                    m_edge(g, s, rdy_s, rst_s);
                    if (rst_s) break;
                    if (!s[r]) begin
                        m_commit(g, rdy_s, 1'b0, 4'h0, 1'b0);
                        break;
                    end
                    hit = (k == DB);
                    m_commit(g, rdy_s, hit, code_of(g, r, c), hit);
                end
                if (rst_s) break;
                if (hit) begin
                    m_phase[g] = 2;
                    cnt = 0;
                    while (cnt < DB) begin
                        m_edge(g, s, rdy_s, rst_s);
                        if (rst_s) break;
                        cnt = (s == 8'h00) ? cnt + 1 : 0;
                        m_commit(g, rdy_s, 1'b0, 4'h0, cnt < DB);
                    end
                    if (rst_s) break;
                end
                c = (c + 1) % ncol;
            end
        end
    endtask

    initial begin
        fork
            run_model(0);
            run_model(1);
        join
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int g = 0; g < 2; g++) begin
                check($sformatf("dut%0d col", g), 64'(col_m[g]), 64'(e_col[g]));
                check($sformatf("dut%0d key_code", g), 64'(code_m[g]), 64'(e_code[g]));
                check($sformatf("dut%0d key_valid", g), 64'(valid_m[g]), 64'(e_valid[g]));
                check($sformatf("dut%0d key_held", g), 64'(held_m[g]), 64'(e_held[g]));
                check($sformatf("dut%0d overflow", g), 64'(ovf_m[g]), 64'(e_ovf[g]));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_phase(input int g, input int ph, input int budget, input string name);
        for (int i = 0; i < budget && m_phase[g] != ph; i++) @(negedge clk);
        check({name, " reached"}, 64'(m_phase[g]), 64'(ph));
    endtask

    task automatic handshake(input int g);
        rdy[g] = 1'b1;
        cyc(1);
        rdy[g] = 1'b0;
    endtask

    int ovf_cnt;

    initial begin
        reset   = 1'b1;
        keys[0] = '0;
        keys[1] = '0;
        rdy[0]  = 1'b0;
        rdy[1]  = 1'b0;
        cyc(3);
        reset  = 1'b0;
        cmp_en = 1'b1;

        // Reset values and idle column sweep.
        check("reset key_code", 64'(code_m[0]), 64'h0);
        check("reset key_valid", 64'(valid_m[0]), 64'h0);
        check("reset key_held", 64'(held_m[0]), 64'h0);
        check("reset overflow", 64'(ovf_m[0]), 64'h0);
        for (int k = 0; k < 20; k++) begin
            check($sformatf("sweep4 k=%0d", k), 64'(col_m[0]), 64'(1 << ((k / 4) % 4)));
            check($sformatf("sweep5 k=%0d", k), 64'(col_m[1]), 64'(1 << ((k / 4) % 5)));
            cyc(1);
        end
        check("sweep key_valid", 64'(valid_m[0]), 64'h0);

        // Row 0 / column 2 on the hex layout is '3'.
        keys[0][0*4 + 2] = 1'b1;
        wait_phase(0, 2, 200, "hex press");
        check("hex key_code", 64'(code_m[0]), 64'h3);
        check("hex model code", 64'(e_code[0]), 64'h3);
        check("hex key_valid", 64'(valid_m[0]), 64'h1);
        check("hex key_held", 64'(held_m[0]), 64'h1);
        handshake(0);
        check("hex valid cleared", 64'(valid_m[0]), 64'h0);
        keys[0] = '0;
        wait_phase(0, 0, 100, "hex release");
        check("col after release", 64'(col_m[0]), 64'h08);

        // Short contact on row 1 / column 0 is rejected as bounce.
        keys[0][1*4 + 0] = 1'b1;
        wait_phase(0, 1, 200, "bounce debounce");
        cyc(2);
        keys[0] = '0;
        wait_phase(0, 0, 50, "bounce reject");
        check("bounce key_valid", 64'(valid_m[0]), 64'h0);
        check("bounce next col", 64'(col_m[0]), 64'h02);
        cyc(20);
        check("bounce still no key", 64'(valid_m[0]), 64'h0);

        // Second press while the first key is unconsumed is dropped with one overflow pulse.
        keys[0][3*4 + 1] = 1'b1;
        wait_phase(0, 2, 200, "ovf first press");
        check("ovf first key_code", 64'(code_m[0]), 64'h0);
        check("ovf first key_valid", 64'(valid_m[0]), 64'h1);
        keys[0] = '0;
        wait_phase(0, 0, 100, "ovf first release");
        keys[0][1*4 + 3] = 1'b1;
        ovf_cnt = 0;
        for (int i = 0; i < 200 && m_phase[0] != 2; i++) begin
            @(negedge clk);
            if (ovf_m[0]) ovf_cnt++;
        end
        repeat (4) begin
            @(negedge clk);
            if (ovf_m[0]) ovf_cnt++;
        end
        check("overflow pulses", 64'(ovf_cnt), 64'd1);
        check("ovf key_code kept", 64'(code_m[0]), 64'h0);
        keys[0] = '0;
        handshake(0);
        check("ovf valid cleared", 64'(valid_m[0]), 64'h0);
        wait_phase(0, 0, 100, "ovf second release");

        // Linear 3x5 layout: row 2 / column 4 is 14; a second key while held is ignored.
        keys[1][2*5 + 4] = 1'b1;
        wait_phase(1, 2, 300, "lin press");
        check("lin key_code", 64'(code_m[1]), 64'd14);
        check("lin key_held", 64'(held_m[1]), 64'h1);
        keys[1][0*5 + 1] = 1'b1;
        ovf_cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (ovf_m[1]) ovf_cnt++;
        end
        check("lin rollover overflow", 64'(ovf_cnt), 64'd0);
        check("lin key_code kept", 64'(code_m[1]), 64'd14);
        check("lin still held", 64'(held_m[1]), 64'h1);
        keys[1][0*5 + 1] = 1'b0;
        cyc(2);
        keys[1] = '0;
        wait_phase(1, 0, 100, "lin release");
        handshake(1);
        check("lin valid cleared", 64'(valid_m[1]), 64'h0);

        // Reset mid-debounce; the still-held key ('7') is reported once after a fresh debounce.
        keys[0][2*4 + 0] = 1'b1;
        wait_phase(0, 1, 200, "rst debounce");
        cyc(2);
        reset = 1'b1;
        cyc(2);
        check("rst col0", 64'(col_m[0]), 64'h01);
        check("rst col1", 64'(col_m[1]), 64'h01);
        check("rst key_valid", 64'(valid_m[0]), 64'h0);
        check("rst key_held", 64'(held_m[0]), 64'h0);
        check("rst key_code", 64'(code_m[0]), 64'h0);
        check("rst overflow", 64'(ovf_m[0]), 64'h0);
        reset = 1'b0;
        wait_phase(0, 2, 200, "rst repress");
        check("rst key_code after", 64'(code_m[0]), 64'h7);
        check("rst key_valid after", 64'(valid_m[0]), 64'h1);
        ovf_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (ovf_m[0]) ovf_cnt++;
        end
        check("rst single report", 64'(ovf_cnt), 64'd0);
        keys[0] = '0;
        handshake(0);
        check("rst valid cleared", 64'(valid_m[0]), 64'h0);
        cyc(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
